// File: rtl/div_sequencer_if.sv
// div_sequencer_if: request/response handshake bundle between EXE and the divide unit
interface div_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;
  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );
  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: iterative 32-bit restoring divider with its own IDLE/BUSY/DONE sequencer
module div_sequencer #(
  parameter bit EARLY_ZERO = 1'b1
) (
  input logic             clk,
  input logic             resetn,
  div_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [31:0] r_src1;
  logic [31:0] r_result;
  logic [1:0]  r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_zero;
  logic        r_resp_valid;
  logic        w_sgn1;
  logic        w_sgn2;
  logic        w_zero;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_borrow;
  logic [32:0] w_rem_nxt;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;
  logic [31:0] w_fin;
  assign w_sgn1    = ~bus.req_op[1] & bus.req_src1[31];
  assign w_sgn2    = ~bus.req_op[1] & bus.req_src2[31];
  assign w_abs1    = w_sgn1 ? -bus.req_src1 : bus.req_src1;
  assign w_abs2    = w_sgn2 ? -bus.req_src2 : bus.req_src2;
  assign w_zero    = bus.req_src2 == 32'd0;
  // r_quo doubles as the dividend shift register: its MSB feeds the remainder, quotient bits enter at the LSB
  assign w_shift   = {r_rem[31:0], r_quo[31]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_div};
  assign w_borrow  = w_diff[33];
  assign w_rem_nxt = w_borrow ? w_shift : w_diff[32:0];
  assign w_q_fin   = {r_quo[30:0], ~w_borrow};
  assign w_r_fin   = w_rem_nxt[31:0];
  assign w_fin     = r_zero ? (r_op[0] ? r_src1 : 32'hFFFF_FFFF)
                   : r_op[0] ? (r_neg_r ? -w_r_fin : w_r_fin)
                   : (r_neg_q ? -w_q_fin : w_q_fin);
  assign bus.req_ready   = (r_state == IDLE) & ~bus.flush;
  assign bus.busy        = r_state != IDLE;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_result;
  // Sequencer: accept, iterate one restoring step per cycle, hold result until consumed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_cnt        <= 5'd0;
      r_rem        <= 33'd0;
      r_quo        <= 32'd0;
      r_div        <= 32'd0;
      r_src1       <= 32'd0;
      r_result     <= 32'd0;
      r_op         <= 2'd0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_zero       <= 1'b0;
      r_resp_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_op    <= bus.req_op;
          r_src1  <= bus.req_src1;
          r_quo   <= w_abs1;
          r_div   <= w_abs2;
          r_rem   <= 33'd0;
          r_cnt   <= 5'd31;
          r_neg_q <= w_sgn1 ^ w_sgn2;
          r_neg_r <= w_sgn1;
          r_zero  <= w_zero;
          if (EARLY_ZERO && w_zero) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_result     <= bus.req_op[0] ? bus.req_src1 : 32'hFFFF_FFFF;
          end else begin
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_q_fin;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_result     <= w_fin;
          end
        end
        DONE: if (bus.resp_ready) begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of latency, arithmetic, divide-by-zero, back-pressure, flush and reset
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b1;
  logic        sel0 = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        rv;
  logic        rrdy;
  logic        rbusy;
  logic [31:0] rres;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  always #5 clk = ~clk;
  div_sequencer_if if1();
  div_sequencer_if if0();
  assign if1.req_valid  = req_valid & ~sel0;
  assign if0.req_valid  = req_valid & sel0;
  assign if1.req_op     = req_op;
  assign if0.req_op     = req_op;
  assign if1.req_src1   = src1;
  assign if0.req_src1   = src1;
  assign if1.req_src2   = src2;
  assign if0.req_src2   = src2;
  assign if1.flush      = flush;
  assign if0.flush      = flush;
  assign if1.resp_ready = resp_ready;
  assign if0.resp_ready = resp_ready;
  assign rv    = sel0 ? if0.resp_valid  : if1.resp_valid;
  assign rrdy  = sel0 ? if0.req_ready   : if1.req_ready;
  assign rbusy = sel0 ? if0.busy        : if1.busy;
  assign rres  = sel0 ? if0.resp_result : if1.resp_result;
  div_sequencer #(.EARLY_ZERO(1'b1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  div_sequencer #(.EARLY_ZERO(1'b0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  // Present a request in the current cycle; it is accepted at the next edge, then operands are scrambled
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op = op; src1 = a; src2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; src1 = 32'hDEAD_BEEF; src2 = 32'h0000_0001;
  endtask
  // lat = cycles after the accepting cycle until resp_valid is seen (bounded)
  task automatic wait_resp(output int l);
    l = 1;
    while (!rv && l < 100) begin @(posedge clk); #1; l++; end
  endtask
  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      sel0 = s[0];
      n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b expected 0", s, rv); end
      n_cmp++; if (rres !== 32'd0) begin n_bad++; $display("FAIL reset_result[%0d]: got %h expected 0", s, rres); end
      n_cmp++; if (rbusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b expected 0", s, rbusy); end
      n_cmp++; if (rrdy !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b expected 1", s, rrdy); end
    end
    sel0 = 1'b0;
  endtask
  task automatic test_basic;
    send(2'b00, 32'd7, 32'd2); wait_resp(lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_lat: got %0d expected 33", lat); end
    n_cmp++; if (rres !== 32'd3) begin n_bad++; $display("FAIL div_7_2: got %h expected 3", rres); end
    @(posedge clk); #1;
    n_cmp++; if (rbusy !== 1'b0 || rrdy !== 1'b1 || rv !== 1'b0) begin n_bad++; $display("FAIL div_idle: got busy=%b ready=%b valid=%b expected 0 1 0", rbusy, rrdy, rv); end
    send(2'b01, 32'd7, 32'd2); wait_resp(lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mod_lat: got %0d expected 33", lat); end
    n_cmp++; if (rres !== 32'd1) begin n_bad++; $display("FAIL mod_7_2: got %h expected 1", rres); end
    @(posedge clk); #1;
  endtask
  task automatic test_signed;
    send(2'b01, 32'hFFFF_FFF9, 32'd2); wait_resp(lat);
    n_cmp++; if (rres !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mod_neg7_2: got %h expected ffffffff", rres); end
    @(posedge clk); #1;
    send(2'b00, 32'hFFFF_FFF9, 32'd2); wait_resp(lat);
    n_cmp++; if (rres !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg7_2: got %h expected fffffffd", rres); end
    @(posedge clk); #1;
    send(2'b10, 32'hFFFF_FFF9, 32'd2); wait_resp(lat);
    n_cmp++; if (rres !== 32'h7FFF_FFFC) begin n_bad++; $display("FAIL divu_big_2: got %h expected 7ffffffc", rres); end
    @(posedge clk); #1;
    send(2'b00, 32'd100, 32'hFFFF_FFF9); wait_resp(lat);
    n_cmp++; if (rres !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL div_100_neg7: got %h expected fffffff2", rres); end
    @(posedge clk); #1;
  endtask
  task automatic test_overflow;
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF); wait_resp(lat);
    n_cmp++; if (rres !== 32'h8000_0000) begin n_bad++; $display("FAIL div_min_m1: got %h expected 80000000", rres); end
    @(posedge clk); #1;
    send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF); wait_resp(lat);
    n_cmp++; if (rres !== 32'd0) begin n_bad++; $display("FAIL mod_min_m1: got %h expected 0", rres); end
    @(posedge clk); #1;
  endtask
  task automatic test_div_zero;
    send(2'b10, 32'd5, 32'd0); wait_resp(lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ez_lat: got %0d expected 1", lat); end
    n_cmp++; if (rres !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ez_divu: got %h expected ffffffff", rres); end
    @(posedge clk); #1;
    send(2'b01, 32'hFFFF_FFF9, 32'd0); wait_resp(lat);
    n_cmp++; if (lat !== 1 || rres !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL ez_mod: got lat=%0d res=%h expected 1 fffffff9", lat, rres); end
    @(posedge clk); #1;
    sel0 = 1'b1;
    send(2'b10, 32'd5, 32'd0); wait_resp(lat);
    n_cmp++; if (lat !== 33 || rres !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL full_divu: got lat=%0d res=%h expected 33 ffffffff", lat, rres); end
    @(posedge clk); #1;
    send(2'b01, 32'hFFFF_FFF9, 32'd0); wait_resp(lat);
    n_cmp++; if (lat !== 33 || rres !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL full_mod: got lat=%0d res=%h expected 33 fffffff9", lat, rres); end
    @(posedge clk); #1;
    send(2'b00, 32'hFFFF_FFF9, 32'd0); wait_resp(lat);
    n_cmp++; if (lat !== 33 || rres !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL full_div_neg: got lat=%0d res=%h expected 33 ffffffff", lat, rres); end
    @(posedge clk); #1;
    sel0 = 1'b0;
  endtask
  task automatic test_backpressure;
    resp_ready = 1'b0;
    send(2'b00, 32'd20, 32'd3); wait_resp(lat);
    n_cmp++; if (lat !== 33 || rres !== 32'd6) begin n_bad++; $display("FAIL bp_first: got lat=%0d res=%h expected 33 6", lat, rres); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (rres !== 32'd6 || rv !== 1'b1 || rrdy !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d]: got res=%h valid=%b ready=%b expected 6 1 0", i, rres, rv, rrdy); end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rbusy !== 1'b0 || rrdy !== 1'b1 || rv !== 1'b0) begin n_bad++; $display("FAIL bp_release: got busy=%b ready=%b valid=%b expected 0 1 0", rbusy, rrdy, rv); end
  endtask
  task automatic test_flush;
    send(2'b00, 32'd1000, 32'd10);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; req_valid = 1'b1; req_op = 2'b10; src1 = 32'd50; src2 = 32'd5;
    #1;
    n_cmp++; if (rrdy !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b expected 0", rrdy); end
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (rbusy !== 1'b0 || rv !== 1'b0) begin n_bad++; $display("FAIL flush_idle: got busy=%b valid=%b expected 0 0", rbusy, rv); end
    send(2'b10, 32'd50, 32'd5); wait_resp(lat);
    n_cmp++; if (lat !== 33 || rres !== 32'd10) begin n_bad++; $display("FAIL after_flush: got lat=%0d res=%h expected 33 a", lat, rres); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid;
    send(2'b00, 32'd1234, 32'd5);
    repeat (14) begin @(posedge clk); #1; end
    #2; resetn = 1'b0; #1;
    n_cmp++; if (rbusy !== 1'b0 || rv !== 1'b0 || rres !== 32'd0 || rrdy !== 1'b1) begin n_bad++; $display("FAIL mid_reset: got busy=%b valid=%b res=%h ready=%b expected 0 0 0 1", rbusy, rv, rres, rrdy); end
    #2; resetn = 1'b1;
    @(posedge clk); #1;
    send(2'b10, 32'd100, 32'd7); wait_resp(lat);
    n_cmp++; if (lat !== 33 || rres !== 32'd14) begin n_bad++; $display("FAIL post_reset: got lat=%0d res=%h expected 33 e", lat, rres); end
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    resetn = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_signed;
    test_overflow;
    test_div_zero;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative 32-bit divide unit with its own sequencing FSM for the execute stage. It serves `div.w`, `mod.w`, `div.wu` and `mod.wu`, which decode signals on `alu_op[15]` to `alu_op[18]`. The EXE stage hands over latched operands through a valid/ready handshake and stalls (`exe_allowin` low) until the result handshake completes. It sits beside the single-cycle ALU and shares none of its logic.

## Interface
- `EARLY_ZERO`, default 1: a zero divisor skips the iteration phase and completes in 1 cycle. When 0, it takes the full 32 iterations.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  EXE presents a divide request.
- `req_ready`  out  1  block can accept; equals (state==IDLE) & ~flush.
- `req_op`  in  2  operation select: 00 `div.w`, 01 `mod.w`, 10 `div.wu`, 11 `mod.wu`.
- `req_src1`  in  32  dividend (rj value).
- `req_src2`  in  32  divisor (rk value).
- `flush`  in  1  kill in-flight operation (exception/redirect).
- `resp_valid`  out  1  `resp_result` is valid.
- `resp_ready`  in  1  EXE/MEM consumes the result.
- `resp_result`  out  32  quotient or remainder.
- `busy`  out  1  state != IDLE.

## Operation
- States:
  - IDLE: `req_ready`=1. Handshake `req_valid&req_ready` latches op, operands and the signs. Next state is BUSY, or DONE if divisor==0 and EARLY_ZERO=1.
  - BUSY: one restoring-division step per cycle. A 5-bit counter loads 31 and decrements; the state leaves BUSY in the cycle the counter is 0. Next state is DONE.
  - DONE: `resp_valid`=1 and `resp_result` is held stable. `resp_valid&resp_ready` returns to IDLE. No new request is accepted in that same cycle.
- Arithmetic:
  - Signed ops (`req_op[1]`=0) divide |src1| by |src2| as 32-bit unsigned magnitudes.
  - Quotient is negated iff the signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops use the raw operands.
- Dividing -2^31 by -1 gives quotient 0x8000_0000 and remainder 0. This falls out of the magnitude path and needs no special case.
- Divide by zero: `div` returns 0xFFFF_FFFF; `mod` returns src1 unchanged, for both signed and unsigned ops.
- Partial remainder register is 33 bits. Each step shifts in the next dividend bit, subtracts the divisor and keeps the difference iff it is non-negative. The quotient bit is the inverted borrow.
- Operands are captured at acceptance. Later changes on `req_src*` have no effect.
- `flush`:
  - Synchronous, overrides every other input.
  - Any state goes to IDLE on the next edge; `resp_valid` is 0 from that edge on and nothing is emitted.
  - A `req_valid` in the same cycle as `flush` is not accepted, because `req_ready` is 0.
- Reset (assert at any time, including mid-BUSY) puts the state in IDLE and clears the counter, the partial remainder and the quotient. Outputs after reset:
  - `resp_valid`=0
  - `resp_result`=0
  - `busy`=0
  - `req_ready`=1

## Timing
- Request accepted at the edge ending cycle T.
  - BUSY occupies cycles T+1 to T+32.
  - `resp_valid` rises in cycle T+33.
  - Fixed latency is 33 cycles to first valid, independent of operand values.
- EARLY_ZERO with divisor 0: `resp_valid` in cycle T+1.
- Back-pressure: while `resp_ready`=0, the block stays in DONE indefinitely with `resp_result` unchanged.
- Result handshake at the edge ending cycle R: IDLE in R+1 with `req_ready`=1. The minimum request-to-request spacing is 34 cycles.
- `resp_result` is registered; there is no combinational path from any input to `resp_result`.
- `req_ready` depends combinationally on `flush` only.

## Test plan
- `div.w` 7 / 2, `resp_ready`=1 → `resp_valid` exactly at T+33, result 3, then IDLE at T+34. Repeat with `mod.w` → 1.
- `mod.w` 0xFFFF_FFF9 (-7) / 2 → 0xFFFF_FFFF (-1). `div.w` of the same operands → 0xFFFF_FFFD (-3). `div.wu` 0xFFFF_FFF9 / 2 → 0x7FFF_FFFC.
- `div.w` 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. `mod.w` of the same → 0.
- Divisor 0 with EARLY_ZERO=1: `div.wu` 5/0 → 0xFFFF_FFFF at T+1; `mod.w` 0xFFFF_FFF9/0 → 0xFFFF_FFF9. With EARLY_ZERO=0, the same results arrive at T+33.
- Back-pressure and flush:
  - Hold `resp_ready`=0 for 10 cycles in DONE → result stable and `req_ready`=0 throughout.
  - Assert `flush` at T+10 → `busy`=0 at T+11 and no `resp_valid`.
  - A new request at T+11 completes correctly at T+44.
- Deassert `resetn` asynchronously mid-BUSY (T+15) → `busy`, `resp_valid` and `resp_result` go to 0 immediately. After release, a fresh 100/7 `div.wu` → 14 with nominal latency.
